// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one cache request at a time and feeds
// Instr/PC/PC+4 to decode. Handles decode redirects (delay slot already issued) and freeze.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Alt_PC_IN,
  input  logic        Request_Alt_PC_IN,
  input  logic        WANT_FREEZE_IN,
  output logic [31:0] Instr_Addr_OUT,
  output logic        Instr_Req_OUT,
  input  logic [31:0] Instr_Data_IN,
  input  logic        Instr_Valid_IN,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4_OUT,
  output logic [31:0] Fetch_Count_OUT
);

  typedef enum logic [1:0] {IDLE, WAIT, FROZEN_EMPTY, FROZEN_FULL} state_t;

  state_t      state;
  logic [31:0] pc_reg;
  logic [31:0] skid_data;
  logic [31:0] skid_pc;
  logic        pend;
  logic [31:0] pend_pc;
  logic [31:0] alt_target;
  logic        redir;
  logic [31:0] redir_pc;

  // A redirect seen this cycle supersedes any older pending target.
  always_comb begin
    alt_target = Alt_PC_IN & ~32'h3;
    redir      = Request_Alt_PC_IN | pend;
    redir_pc   = Request_Alt_PC_IN ? alt_target : pend_pc;
  end

  assign Instr_Addr_OUT = pc_reg;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state              <= IDLE;
      pc_reg             <= RESET_PC;
      skid_data          <= '0;
      skid_pc            <= '0;
      pend               <= 1'b0;
      pend_pc            <= '0;
      Instr_Req_OUT      <= 1'b0;
      Instr1_OUT         <= NOP_INSTR;
      Instr_PC_OUT       <= '0;
      Instr_PC_Plus4_OUT <= 32'd4;
      Fetch_Count_OUT    <= '0;
    end else begin
      // Capture is overridden below on the edges that consume the redirect.
      if (state != IDLE && Request_Alt_PC_IN) begin
        pend    <= 1'b1;
        pend_pc <= alt_target;
      end
      case (state)
        IDLE: begin
          state         <= WAIT;
          Instr_Req_OUT <= 1'b1;
        end
        WAIT: begin
          if (WANT_FREEZE_IN) begin
            Instr_Req_OUT <= 1'b0;
            if (Instr_Valid_IN) begin
              skid_data <= Instr_Data_IN;
              skid_pc   <= pc_reg;
              state     <= FROZEN_FULL;
            end else begin
              state <= FROZEN_EMPTY;
            end
          end else if (Instr_Valid_IN) begin
            Instr_PC_OUT       <= pc_reg;
            Instr_PC_Plus4_OUT <= pc_reg + 32'd4;
            if (redir) begin
              Instr1_OUT <= NOP_INSTR;
              pc_reg     <= redir_pc;
              pend       <= 1'b0;
            end else begin
              Instr1_OUT      <= Instr_Data_IN;
              pc_reg          <= pc_reg + 32'd4;
              Fetch_Count_OUT <= Fetch_Count_OUT + 32'd1;
            end
          end
        end
        FROZEN_EMPTY: begin
          if (!WANT_FREEZE_IN) begin
            state         <= WAIT;
            Instr_Req_OUT <= 1'b1;
            if (redir) begin
              pc_reg <= redir_pc;
              pend   <= 1'b0;
            end
          end
        end
        FROZEN_FULL: begin
          if (!WANT_FREEZE_IN) begin
            state              <= WAIT;
            Instr_Req_OUT      <= 1'b1;
            Instr_PC_OUT       <= skid_pc;
            Instr_PC_Plus4_OUT <= skid_pc + 32'd4;
            if (redir) begin
              Instr1_OUT <= NOP_INSTR;
              pc_reg     <= redir_pc;
              pend       <= 1'b0;
            end else begin
              Instr1_OUT      <= skid_data;
              pc_reg          <= skid_pc + 32'd4;
              Fetch_Count_OUT <= Fetch_Count_OUT + 32'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
